// File: rtl/fixed_mult_seq.sv
// Sequential signed Q(WIDTH-FRAC).FRAC multiplier: iterative shift-add over a valid/ready handshake.
// Result after WIDTH+1 cycles and held in DONE until out_ready. `define SATURATE_EN to clamp on overflow.
module fixed_mult_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             precision_lost,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_sign;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_result;
  logic                 r_overflow;
  logic                 r_prec;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_mag;
  logic [2*WIDTH-1:0]   w_lim;
  logic                 w_ovf;
  logic                 w_pl;
  logic [WIDTH-1:0]     w_wrap;
  logic [WIDTH-1:0]     w_res;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  // Negating the most-negative value yields 2^(W-1), which is correct as unsigned.
  assign w_abs_a  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_abs_b  = b[WIDTH-1] ? (~b + 1'b1) : b;

  assign w_mag  = r_acc >> FRAC;
  assign w_pl   = |r_acc[FRAC-1:0];
  assign w_lim  = r_sign ? {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}}
                         : ({{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}} - (2*WIDTH)'(1));
  assign w_ovf  = (w_mag > w_lim);
  assign w_wrap = r_sign ? (~w_mag[WIDTH-1:0] + 1'b1) : w_mag[WIDTH-1:0];

`ifdef SATURATE_EN
  assign w_res = w_ovf ? (r_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                       : w_wrap;
`else
  assign w_res = w_wrap;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: if (w_last)   w_next = S_NORM;
      S_NORM:               w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default:              w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_sign     <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_prec     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
          r_mplier <= w_abs_b;
          r_sign   <= a[WIDTH-1] ^ b[WIDTH-1];
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        S_CALC: begin
          // Multiplicand shifts up as multiplier bits are consumed LSB first.
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        S_NORM: begin
          r_result   <= w_res;
          r_overflow <= w_ovf;
          r_prec     <= w_pl;
        end
        default: ;
      endcase
    end
  end

  assign result         = r_result;
  assign overflow       = r_overflow;
  assign precision_lost = r_prec;

endmodule

// File: tb/tb_fixed_mult_seq.sv
// Directed-vector bench for fixed_mult_seq (WIDTH=32, FRAC=16).
module tb_fixed_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        precision_lost;
  logic        busy;

  int n_tests;
  int n_fail;

  fixed_mult_seq #(.WIDTH(32), .FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .precision_lost(precision_lost), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accepts one operand pair and waits for out_valid, leaving the result held in DONE.
  task automatic start_and_wait(input logic [31:0] av, input logic [31:0] bv, output int lat);
    @(negedge clk);
    check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_r, input logic exp_ov, input logic exp_pl);
    int lat;
    start_and_wait(av, bv, lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'd33);
    check_eq({tag, "_result"}, 64'(result), 64'(exp_r));
    check_eq({tag, "_overflow"}, 64'(overflow), 64'(exp_ov));
    check_eq({tag, "_prec"}, 64'(precision_lost), 64'(exp_pl));
    release_result();
    check_eq({tag, "_idle_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic        held_ov;
    logic        held_pl;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_flags", 64'({overflow, precision_lost}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec("signs", 32'hFFFF8000, 32'hFFFF0000, 32'h00008000, 1'b0, 1'b0);
`ifdef SATURATE_EN
    run_vec("ovf_pos", 32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF, 1'b1, 1'b0);
    run_vec("ovf_neg", 32'h80000000, 32'h00010001, 32'h80000000, 1'b1, 1'b0);
`else
    run_vec("ovf_pos", 32'h7FFF0000, 32'h00020000, 32'hFFFE0000, 1'b1, 1'b0);
    run_vec("ovf_neg", 32'h80000000, 32'h00010001, 32'h7FFF8000, 1'b1, 1'b0);
`endif
    run_vec("prec_pos", 32'h00000001, 32'h00008000, 32'h00000000, 1'b0, 1'b1);
    run_vec("prec_negzero", 32'hFFFFFFFF, 32'h00008000, 32'h00000000, 1'b0, 1'b1);
    run_vec("most_neg", 32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0);
    run_vec("max_pos", 32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_vec("frac_mix", 32'h00018000, 32'h00028000, 32'h0003C000, 1'b0, 1'b0);
    run_vec("neg_prod", 32'h00030000, 32'hFFFE0000, 32'hFFFA0000, 1'b0, 1'b0);

    // Backpressure: result held while a competing in_valid is ignored.
    start_and_wait(32'h00018000, 32'hFFFF0000, lat);
    check_eq("bp_latency", 64'(lat), 64'd33);
    check_eq("bp_result", 64'(result), 64'hFFFE8000);
    held = result; held_ov = overflow; held_pl = precision_lost;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 32'h00020000; b = 32'h00020000; in_valid = 1'b1;
      check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
      check_eq("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_hold_result", 64'(result), 64'(held));
      check_eq("bp_hold_flags", 64'({overflow, precision_lost}), 64'({held_ov, held_pl}));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_release_in_ready", 64'(in_ready), 64'd1);
    check_eq("bp_release_out_valid", 64'(out_valid), 64'd0);
    check_eq("bp_release_busy", 64'(busy), 64'd0);

    // Reset at CALC iteration 10 discards the operation.
    @(negedge clk);
    a = 32'h00050000; b = 32'h00030000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check_eq("mid_busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_result", 64'(result), 64'd0);
    check_eq("mid_rst_flags", 64'({overflow, precision_lost}), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("mid_rst_no_valid", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst", 32'h00020000, 32'hFFFD0000, 32'hFFFA0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
